// File: rtl/alu_issue_buffer_pkg.sv
// Shared widths, op-codes, controller states and the entry record for the ALU issue buffer.
// The ALU_ISSUE_BYPASS_EN build uses the bypass helper defined here.
package alu_issue_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 6;
    localparam int REG_AW     = 5;

    localparam logic [OP_WIDTH-1:0] OP_ALU_NOP = 6'd0;
    localparam logic [OP_WIDTH-1:0] OP_ALU_ADD = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SUB = 6'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [REG_AW-1:0]     rd;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
    } entry_t;

    // Late writeback forwarding; x0 is hard-wired zero and never forwarded.
    function automatic entry_t bypass(input entry_t e, input logic wb_en,
                                      input logic [REG_AW-1:0] wb_rd,
                                      input logic [DATA_WIDTH-1:0] wb_data);
        entry_t r;
        r = e;
        if (wb_en && (wb_rd != '0) && (wb_rd == e.rs1)) r.a = wb_data;
        if (wb_en && (wb_rd != '0) && (wb_rd == e.rs2)) r.b = wb_data;
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_buffer_slot.sv
// One issue-buffer entry: valid flag plus op/operand record, with load/clear.
// With ALU_ISSUE_BYPASS_EN defined, operands also capture matching writebacks.
module alu_issue_buffer_slot
    import alu_issue_buffer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  entry_t                i_data,
    input  logic                  i_wb_en,
    input  logic [REG_AW-1:0]     i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_valid,
    output entry_t                o_data
);

    logic   r_valid;
    entry_t r_data;
    entry_t w_next;

`ifdef ALU_ISSUE_BYPASS_EN
    // Forwarding applies both to the held entry and to the one being loaded.
    assign w_next = bypass(i_load ? i_data : r_data, i_wb_en, i_wb_rd, i_wb_data);
`else
    logic w_unused;
    assign w_unused = ^{i_wb_en, i_wb_rd, i_wb_data};
    assign w_next   = i_load ? i_data : r_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end
            r_data <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_issue_buffer.sv
// Two-entry (main + skid) issue buffer in front of the ALU with registered o_ready.
// Optional operand forwarding from writeback is enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue_buffer
    import alu_issue_buffer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [OP_WIDTH-1:0]   i_alu_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [REG_AW-1:0]     i_rd,
    input  logic [REG_AW-1:0]     i_rs1,
    input  logic [REG_AW-1:0]     i_rs2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [REG_AW-1:0]     o_rd,
    input  logic                  i_wb_en,
    input  logic [REG_AW-1:0]     i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data
);

    state_t r_state, w_state_nxt;
    logic   r_ready;

    entry_t w_in, w_main_in, w_main_data, w_skid_data;
    logic   w_main_valid, w_skid_valid;
    logic   w_push, w_pop;
    logic   w_main_load, w_main_clear, w_main_sel_skid;
    logic   w_skid_load, w_skid_clear;
    logic   w_unused;

    assign w_in      = '{op: i_alu_op, a: i_a, b: i_b, rd: i_rd, rs1: i_rs1, rs2: i_rs2};
    assign w_push    = i_valid & r_ready;
    assign w_pop     = w_main_valid & i_ready;
    assign w_main_in = w_main_sel_skid ? w_skid_data : w_in;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_load     = 1'b0;
        w_main_clear    = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_main_load = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_main_load = 1'b1;
                end else if (w_push) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_pop) begin
                    w_main_clear = 1'b1;
                    w_state_nxt  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_main_load     = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_skid_clear    = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything, including a push arriving in the same cycle.
        if (i_flush) begin
            w_state_nxt  = ST_EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_FULL);
        end
    end

    alu_issue_buffer_slot u_main (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_main_load),
        .i_clear   (w_main_clear),
        .i_data    (w_main_in),
        .i_wb_en   (i_wb_en),
        .i_wb_rd   (i_wb_rd),
        .i_wb_data (i_wb_data),
        .o_valid   (w_main_valid),
        .o_data    (w_main_data)
    );

    alu_issue_buffer_slot u_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_skid_load),
        .i_clear   (w_skid_clear),
        .i_data    (w_in),
        .i_wb_en   (i_wb_en),
        .i_wb_rd   (i_wb_rd),
        .i_wb_data (i_wb_data),
        .o_valid   (w_skid_valid),
        .o_data    (w_skid_data)
    );

    assign w_unused = ^{w_main_data.rs1, w_main_data.rs2, w_skid_valid};

    assign o_ready  = r_ready;
    assign o_valid  = w_main_valid;
    assign o_alu_op = w_main_data.op;
    assign o_a      = w_main_data.a;
    assign o_b      = w_main_data.b;
    assign o_rd     = w_main_data.rd;

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Scoreboard bench for alu_issue_buffer; expected ops are queued on accepted pushes
// and compared on each pop, with o_valid/o_ready checked against the queue occupancy.
module tb_alu_issue_buffer;
    import alu_issue_buffer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst = 1'b1, flush = 1'b0, valid = 1'b0, ready_in = 1'b0;
    logic                  wb_en = 1'b0;
    logic [REG_AW-1:0]     wb_rd = '0;
    logic [DATA_WIDTH-1:0] wb_data = '0;
    entry_t                din = '0;
    logic                  o_ready, o_valid;
    logic [OP_WIDTH-1:0]   o_alu_op;
    logic [DATA_WIDTH-1:0] o_a, o_b;
    logic [REG_AW-1:0]     o_rd;

    entry_t q[$];
    int n_vec = 0;
    int n_err = 0;

    alu_issue_buffer dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_alu_op(din.op), .i_a(din.a), .i_b(din.b), .i_rd(din.rd),
        .i_rs1(din.rs1), .i_rs2(din.rs2),
        .o_valid(o_valid), .i_ready(ready_in), .o_alu_op(o_alu_op), .o_a(o_a), .o_b(o_b),
        .o_rd(o_rd), .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data)
    );

    function automatic entry_t bp(input entry_t e);
        entry_t r;
        r = e;
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_en && wb_rd != 0 && wb_rd == e.rs1) r.a = wb_data;
        if (wb_en && wb_rd != 0 && wb_rd == e.rs2) r.b = wb_data;
`endif
        return r;
    endfunction

    function automatic entry_t mk(input logic [OP_WIDTH-1:0] op, input int a, input int b,
                                  input int rd, input int rs1, input int rs2);
        entry_t e;
        e.op = op; e.a = DATA_WIDTH'(a); e.b = DATA_WIDTH'(b);
        e.rd = REG_AW'(rd); e.rs1 = REG_AW'(rs1); e.rs2 = REG_AW'(rs2);
        return e;
    endfunction

    // Called at a falling edge with inputs already set; advances one clock.
    task automatic tick();
        entry_t e;
        bit do_pop, do_push;
        logic exp_v, exp_r;
        exp_v   = (q.size() > 0);
        exp_r   = (q.size() < 2);
        do_pop  = (o_valid === 1'b1) && ready_in && !rst;
        do_push = valid && (o_ready === 1'b1) && !rst && !flush;
        n_vec++;
        if (o_valid !== exp_v) begin
            n_err++;
            $display("FAIL o_valid: got %b expected %b", o_valid, exp_v);
        end
        n_vec++;
        if (o_ready !== exp_r) begin
            n_err++;
            $display("FAIL o_ready: got %b expected %b", o_ready, exp_r);
        end
        if (do_pop && q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({o_alu_op, o_a, o_b, o_rd} !== {e.op, e.a, e.b, e.rd}) begin
                n_err++;
                $display("FAIL pop_data: got op=%0d a=%h b=%h rd=%0d expected op=%0d a=%h b=%h rd=%0d",
                         o_alu_op, o_a, o_b, o_rd, e.op, e.a, e.b, e.rd);
            end
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            foreach (q[i]) q[i] = bp(q[i]);
            if (do_push) q.push_back(bp(din));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        valid = 1'b0; ready_in = 1'b1; flush = 1'b0; wb_en = 1'b0;
        for (int k = 0; k < 8 && q.size() > 0; k++) tick();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d ops still pending, expected 0", q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; din = mk(OP_ALU_ADD, 9, 9, 1, 0, 0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        q.delete();
        n_vec++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_hs: got valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
        end
        n_vec++;
        if ({o_alu_op, o_a, o_b, o_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got op=%0d a=%h b=%h rd=%0d expected all zero", o_alu_op, o_a, o_b, o_rd);
        end
        tick();
    endtask

    task automatic test_stream();
        ready_in = 1'b1; valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = (i < 4) ? mk(OP_ALU_ADD, 5, 7, 3, 0, 0) : mk(OP_ALU_ADD, 3 * i, 100 + i, i, 0, 0);
            tick();
            if (i == 0) begin
                n_vec++;
                if (o_valid !== 1'b1 || (o_a + o_b) !== 32'd12) begin
                    n_err++;
                    $display("FAIL stream_first: got valid=%b a+b=%0d expected valid=1 a+b=12", o_valid, o_a + o_b);
                end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        entry_t a_op;
        bit acc;
        a_op = mk(OP_ALU_ADD, 32'h11, 32'h12, 4, 0, 0);
        ready_in = 1'b0; valid = 1'b1;
        din = a_op; tick();
        din = mk(OP_ALU_SUB, 32'h21, 32'h22, 5, 0, 0); tick();
        din = mk(OP_ALU_ADD, 32'h31, 32'h32, 6, 0, 0);
        tick(); tick();
        n_vec++;
        if (o_a !== a_op.a || o_rd !== a_op.rd) begin
            n_err++;
            $display("FAIL stall_hold: got a=%h rd=%0d expected a=%h rd=%0d", o_a, o_rd, a_op.a, a_op.rd);
        end
        ready_in = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            acc = (o_ready === 1'b1);
            tick();
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL c_accept: op C not accepted, expected acceptance after release");
        end
        drain();
    endtask

    task automatic test_flush();
        ready_in = 1'b0; valid = 1'b1;
        din = mk(OP_ALU_ADD, 1, 2, 7, 0, 0); tick();
        din = mk(OP_ALU_ADD, 3, 4, 8, 0, 0); tick();
        flush = 1'b1; din = mk(OP_ALU_SUB, 32'hdead, 32'hbeef, 9, 0, 0); tick();
        flush = 1'b0; valid = 1'b0;
        n_vec++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_full: got valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
        end
        ready_in = 1'b1;
        tick(); tick();
        // Flush coinciding with a pop and a push.
        valid = 1'b1; din = mk(OP_ALU_ADD, 10, 20, 2, 0, 0); tick();
        flush = 1'b1; din = mk(OP_ALU_ADD, 30, 40, 3, 0, 0); tick();
        flush = 1'b0; valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_midstall();
        ready_in = 1'b0; valid = 1'b1;
        din = mk(OP_ALU_ADD, 50, 60, 10, 0, 0); tick();
        din = mk(OP_ALU_ADD, 70, 80, 11, 0, 0); tick();
        valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; ready_in = 1'b1;
        n_vec++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_midstall: got valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_bypass();
        logic [DATA_WIDTH-1:0] exp_a, exp_b;
        ready_in = 1'b0; valid = 1'b1;
        din = mk(OP_ALU_SUB, 1, 2, 7, 4, 0); tick();
        valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h10; tick();
`ifdef ALU_ISSUE_BYPASS_EN
        exp_a = 32'h10;
`else
        exp_a = 32'h1;
`endif
        exp_b = 32'h2;
        n_vec++;
        if (o_a !== exp_a || o_b !== exp_b) begin
            n_err++;
            $display("FAIL bypass_rs1: got a=%h b=%h expected a=%h b=%h", o_a, o_b, exp_a, exp_b);
        end
        wb_rd = 5'd0; wb_data = 32'h55; tick();
        n_vec++;
        if (o_a !== exp_a || o_b !== exp_b) begin
            n_err++;
            $display("FAIL bypass_x0: got a=%h b=%h expected a=%h b=%h", o_a, o_b, exp_a, exp_b);
        end
        valid = 1'b1; din = mk(OP_ALU_ADD, 3, 4, 8, 9, 6);
        wb_rd = 5'd9; wb_data = 32'h77; tick();
        valid = 1'b0; wb_rd = 5'd6; wb_data = 32'h20; tick();
        wb_en = 1'b0;
        n_vec++;
        if (o_a !== exp_a || o_b !== exp_b) begin
            n_err++;
            $display("FAIL bypass_rs2_other: got a=%h b=%h expected a=%h b=%h", o_a, o_b, exp_a, exp_b);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_reset_midstall();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
